// File: rtl/mem_stage_vlat.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_vlat
// Description : Memory-access pipeline stage for a variable-latency data SRAM
//               with a split request/response interface. The request is
//               issued in EXE, and this stage waits for the matching data_ok.
//               The stage does the following:
//                 - aligns and extends load data
//                 - optionally completes the multiplier final add
//                 - produces forwarding info for ID
//                 - buffers an early response while WB stalls
//                 - discards responses that belong to flushed instructions
// Ports       : clk, resetn (async active-low), flush
//               in_*               : instruction fields from EXE
//               data_sram_data_ok/_rdata : SRAM response channel
//               wb_allowin / mem_allowin : pipeline handshake
//               out_*              : instruction fields and result to WB
//               fwd_dest/fwd_from_mem/fwd_pending : forwarding info to ID
// Macros      : MEM_MUL_FINAL_ADD_EN
//               When defined, the stage performs the multiplier final add.
//               When undefined, no adder is built, the in_add1/in_add2/
//               in_cin/in_mul_op ports are ignored, and the non-load result
//               is exe_result.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_vlat #(
    parameter int PC_W      = 32,
    parameter int DATA_W    = 32,   // byte/half alignment assumes 32
    parameter int DEST_W    = 5,
    parameter int MUL_W     = 68,
    parameter int MAX_OUTST = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [PC_W-1:0]   in_pc,
    input  logic              in_gr_we,
    input  logic [DEST_W-1:0] in_dest,
    input  logic [DATA_W-1:0] in_exe_result,
    input  logic              in_mem_req,
    input  logic [4:0]        in_load_op,
    input  logic              in_rfrom_mem,
    input  logic [2:0]        in_mul_op,
    input  logic [MUL_W-1:0]  in_add1,
    input  logic [MUL_W-1:0]  in_add2,
    input  logic              in_cin,
    input  logic              data_sram_data_ok,
    input  logic [DATA_W-1:0] data_sram_rdata,
    input  logic              wb_allowin,
    output logic              mem_allowin,
    output logic              out_valid,
    output logic [PC_W-1:0]   out_pc,
    output logic              out_gr_we,
    output logic [DEST_W-1:0] out_dest,
    output logic [DATA_W-1:0] out_result,
    output logic [DEST_W-1:0] fwd_dest,
    output logic              fwd_from_mem,
    output logic              fwd_pending
);

    localparam int CNT_W = $clog2(MAX_OUTST + 1);
    // Two extra bits let the unsaturated sum exceed MAX_OUTST without wrapping.
    localparam int SUM_W = CNT_W + 2;
    localparam logic [SUM_W-1:0] c_cnt_max_wide = SUM_W'(MAX_OUTST);
    localparam logic [CNT_W-1:0] c_cnt_max      = CNT_W'(MAX_OUTST);

    // ------------------------------------------------------------------------
    // Stage registers
    // ------------------------------------------------------------------------
    logic              r_valid;
    logic [PC_W-1:0]   r_pc;
    logic              r_gr_we;
    logic [DEST_W-1:0] r_dest;
    logic [DATA_W-1:0] r_exe_result;
    logic              r_mem_req;
    logic [4:0]        r_load_op;
    logic              r_rfrom_mem;
    logic              r_got_data;
    logic [DATA_W-1:0] r_data_buf;
    logic [CNT_W-1:0]  r_discard_cnt;

    logic              w_latch;
    logic              w_stale;
    logic              w_match;
    logic              w_ready_go;
    logic              w_inc_cur;
    logic              w_inc_new;
    logic [SUM_W-1:0]  w_cnt_sum;
    logic [DATA_W-1:0] w_src;
    logic [DATA_W-1:0] w_shifted;
    logic [DATA_W-1:0] w_load_data;
    logic [DATA_W-1:0] w_alu_result;

    assign w_latch = in_valid && mem_allowin && !flush;

    // Outstanding responses of killed instructions come back first, so
    // any data_ok seen while the discard counter is non-zero belongs to
    // them and must never be matched to the current instruction.
    assign w_stale    = data_sram_data_ok && (r_discard_cnt != '0);
    assign w_match    = data_sram_data_ok && !w_stale && r_valid && r_mem_req && !r_got_data;
    assign w_ready_go = !r_mem_req || r_got_data || w_match;

    assign out_valid   = r_valid && w_ready_go && !flush;
    assign mem_allowin = !r_valid || (w_ready_go && wb_allowin);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_valid <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (mem_allowin) begin
            r_valid <= in_valid;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pc         <= '0;
            r_gr_we      <= 1'b0;
            r_dest       <= '0;
            r_exe_result <= '0;
            r_mem_req    <= 1'b0;
            r_load_op    <= '0;
            r_rfrom_mem  <= 1'b0;
        end else if (w_latch) begin
            r_pc         <= in_pc;
            r_gr_we      <= in_gr_we;
            r_dest       <= in_dest;
            r_exe_result <= in_exe_result;
            r_mem_req    <= in_mem_req;
            r_load_op    <= in_load_op;
            r_rfrom_mem  <= in_rfrom_mem;
        end
    end

    // An early response is parked here while WB is stalled. The flag
    // drops when the instruction is handed to WB or killed.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_got_data <= 1'b0;
            r_data_buf <= '0;
        end else if (flush) begin
            r_got_data <= 1'b0;
        end else if (w_match && !wb_allowin) begin
            r_got_data <= 1'b1;
            r_data_buf <= data_sram_rdata;
        end else if (out_valid && wb_allowin) begin
            r_got_data <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Discard counter
    // Both the killed MEM instruction, if its response is still owed, and
    // an incoming EXE instruction whose request was already accepted leave
    // a response in flight. A stale response arriving in the same cycle
    // nets out.
    // ------------------------------------------------------------------------
    assign w_inc_cur = flush && r_valid && r_mem_req && !r_got_data && !w_match;
    assign w_inc_new = flush && in_valid && in_mem_req;
    assign w_cnt_sum = SUM_W'(r_discard_cnt) + SUM_W'(w_inc_cur)
                     + SUM_W'(w_inc_new) - SUM_W'(w_stale);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_discard_cnt <= '0;
        end else if (w_cnt_sum > c_cnt_max_wide) begin
            r_discard_cnt <= c_cnt_max;
        end else begin
            r_discard_cnt <= w_cnt_sum[CNT_W-1:0];
        end
    end

`ifndef SYNTHESIS
    a_discard_no_overflow : assert property (@(posedge clk) disable iff (!resetn)
        w_cnt_sum <= c_cnt_max_wide)
        else $error("mem_stage_vlat: discard counter overflow (too many outstanding requests)");
`endif

    // ------------------------------------------------------------------------
    // Load alignment and extension
    // ------------------------------------------------------------------------
    assign w_src     = r_got_data ? r_data_buf : data_sram_rdata;
    assign w_shifted = w_src >> {r_exe_result[1:0], 3'b000};

    always_comb begin
        w_load_data = w_shifted;
        if (r_load_op[0]) begin
            w_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
        end else if (r_load_op[1]) begin
            w_load_data = {24'b0, w_shifted[7:0]};
        end else if (r_load_op[2]) begin
            w_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
        end else if (r_load_op[3]) begin
            w_load_data = {16'b0, w_shifted[15:0]};
        end else if (r_load_op[4]) begin
            w_load_data = w_shifted;
        end
    end

    // ------------------------------------------------------------------------
    // Non-load result (optional multiplier final add)
    // ------------------------------------------------------------------------
`ifdef MEM_MUL_FINAL_ADD_EN
    logic [2:0]       r_mul_op;
    logic [MUL_W-1:0] r_add1;
    logic [MUL_W-1:0] r_add2;
    logic             r_cin;
    logic [MUL_W-1:0] w_sum;
    logic             w_unused_sum;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_mul_op <= '0;
            r_add1   <= '0;
            r_add2   <= '0;
            r_cin    <= 1'b0;
        end else if (w_latch) begin
            r_mul_op <= in_mul_op;
            r_add1   <= in_add1;
            r_add2   <= in_add2;
            r_cin    <= in_cin;
        end
    end

    assign w_sum = r_add1 + r_add2 + MUL_W'(r_cin);
    // Bits above 63 are only sign/guard bits of the partial-sum format.
    assign w_unused_sum = ^w_sum;

    always_comb begin
        w_alu_result = r_exe_result;
        if (r_mul_op[2]) begin
            w_alu_result = w_sum[31:0];
        end else if (r_mul_op[1] || r_mul_op[0]) begin
            w_alu_result = w_sum[63:32];
        end
    end
`else
    logic w_unused_mul;

    assign w_unused_mul = ^{in_add1, in_add2, in_cin, in_mul_op};
    assign w_alu_result = r_exe_result;
`endif

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign out_pc     = r_pc;
    assign out_gr_we  = r_gr_we;
    assign out_dest   = r_dest;
    assign out_result = r_rfrom_mem ? w_load_data : w_alu_result;

    assign fwd_dest     = (r_valid && r_gr_we) ? r_dest : '0;
    assign fwd_from_mem = r_valid && r_rfrom_mem;
    assign fwd_pending  = r_valid && r_rfrom_mem && !w_ready_go;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_vlat.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage_vlat
// Description : Directed testbench for mem_stage_vlat. The stimulus pushes
//               the expected WB transfers into a queue, and a monitor on the
//               falling edge pops and compares them on every out_valid &&
//               wb_allowin handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage_vlat;

    localparam int PC_W   = 32;
    localparam int DATA_W = 32;
    localparam int DEST_W = 5;
    localparam int MUL_W  = 68;

    localparam logic [4:0] c_ld_b  = 5'b00001;
    localparam logic [4:0] c_ld_bu = 5'b00010;
    localparam logic [4:0] c_ld_hu = 5'b01000;
    localparam logic [4:0] c_ld_w  = 5'b10000;

    logic              clk = 1'b0;
    logic              resetn;
    logic              flush;
    logic              in_valid;
    logic [PC_W-1:0]   in_pc;
    logic              in_gr_we;
    logic [DEST_W-1:0] in_dest;
    logic [DATA_W-1:0] in_exe_result;
    logic              in_mem_req;
    logic [4:0]        in_load_op;
    logic              in_rfrom_mem;
    logic [2:0]        in_mul_op;
    logic [MUL_W-1:0]  in_add1;
    logic [MUL_W-1:0]  in_add2;
    logic              in_cin;
    logic              data_sram_data_ok;
    logic [DATA_W-1:0] data_sram_rdata;
    logic              wb_allowin;
    logic              mem_allowin;
    logic              out_valid;
    logic [PC_W-1:0]   out_pc;
    logic              out_gr_we;
    logic [DEST_W-1:0] out_dest;
    logic [DATA_W-1:0] out_result;
    logic [DEST_W-1:0] fwd_dest;
    logic              fwd_from_mem;
    logic              fwd_pending;

    always #5 clk = ~clk;

    mem_stage_vlat #(
        .PC_W(PC_W), .DATA_W(DATA_W), .DEST_W(DEST_W), .MUL_W(MUL_W), .MAX_OUTST(2)
    ) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(in_valid), .in_pc(in_pc), .in_gr_we(in_gr_we), .in_dest(in_dest),
        .in_exe_result(in_exe_result), .in_mem_req(in_mem_req), .in_load_op(in_load_op),
        .in_rfrom_mem(in_rfrom_mem), .in_mul_op(in_mul_op), .in_add1(in_add1),
        .in_add2(in_add2), .in_cin(in_cin), .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata(data_sram_rdata), .wb_allowin(wb_allowin), .mem_allowin(mem_allowin),
        .out_valid(out_valid), .out_pc(out_pc), .out_gr_we(out_gr_we), .out_dest(out_dest),
        .out_result(out_result), .fwd_dest(fwd_dest), .fwd_from_mem(fwd_from_mem),
        .fwd_pending(fwd_pending)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] res;
        logic [4:0]  dest;
    } exp_t;

    exp_t sb[$];
    int   nchk  = 0;
    int   nbad  = 0;
    int   nxfer = 0;
    int   npush = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] res, input logic [4:0] dest);
        exp_t e;
        e.pc   = pc;
        e.res  = res;
        e.dest = dest;
        sb.push_back(e);
        npush++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid          = 1'b0;
        in_mem_req        = 1'b0;
        flush             = 1'b0;
        data_sram_data_ok = 1'b0;
    endtask

    task automatic enter_load(input logic [31:0] pc, input logic [4:0] dest,
                              input logic [31:0] addr, input logic [4:0] op);
        in_valid      = 1'b1;
        in_pc         = pc;
        in_gr_we      = 1'b1;
        in_dest       = dest;
        in_exe_result = addr;
        in_mem_req    = 1'b1;
        in_load_op    = op;
        in_rfrom_mem  = 1'b1;
        in_mul_op     = 3'b000;
    endtask

    task automatic enter_alu(input logic [31:0] pc, input logic [4:0] dest,
                             input logic [31:0] res, input logic [2:0] mop);
        in_valid      = 1'b1;
        in_pc         = pc;
        in_gr_we      = 1'b1;
        in_dest       = dest;
        in_exe_result = res;
        in_mem_req    = 1'b0;
        in_load_op    = 5'b00000;
        in_rfrom_mem  = 1'b0;
        in_mul_op     = mop;
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        exp_t e;
        if (resetn && out_valid && wb_allowin) begin
            nxfer++;
            if (sb.size() == 0) begin
                nchk++;
                nbad++;
                $display("FAIL unexpected_out: got pc %0h result %0h, expected no transfer",
                         out_pc, out_result);
            end else begin
                e = sb.pop_front();
                check("out_result", {32'b0, out_result}, {32'b0, e.res});
                check("out_pc", {32'b0, out_pc}, {32'b0, e.pc});
                check("out_dest", {59'b0, out_dest}, {59'b0, e.dest});
            end
        end
    end

    initial begin
        int x0;
        resetn = 1'b0;
        idle();
        in_pc = '0; in_gr_we = 1'b0; in_dest = '0; in_exe_result = '0;
        in_load_op = '0; in_rfrom_mem = 1'b0; in_mul_op = '0;
        in_add1 = '0; in_add2 = '0; in_cin = 1'b0;
        data_sram_rdata = '0;
        wb_allowin = 1'b1;
        #1;
        // reset state
        check("rst_out_valid", {63'b0, out_valid}, 64'd0);
        check("rst_fwd_dest", {59'b0, fwd_dest}, 64'd0);
        check("rst_fwd_pending", {63'b0, fwd_pending}, 64'd0);
        check("rst_mem_allowin", {63'b0, mem_allowin}, 64'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        step();

        // 1: LD_B at byte 3, response two cycles after entry
        enter_load(32'h100, 5'd5, 32'h0000_1003, c_ld_b);
        push(32'h100, 32'hFFFF_FF80, 5'd5);
        step();
        idle();
        #1;
        check("t1_pending_c0", {63'b0, fwd_pending}, 64'd1);
        check("t1_fwd_dest", {59'b0, fwd_dest}, 64'd5);
        check("t1_fwd_from_mem", {63'b0, fwd_from_mem}, 64'd1);
        step();
        check("t1_pending_c1", {63'b0, fwd_pending}, 64'd1);
        check("t1_no_out", {63'b0, out_valid}, 64'd0);
        step();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h80FF_FF12;
        #1;
        check("t1_out_valid", {63'b0, out_valid}, 64'd1);
        check("t1_pending_done", {63'b0, fwd_pending}, 64'd0);
        step();
        idle();

        // 2: LD_HU at half 2, response while WB stalls, buffered
        x0 = nxfer;
        wb_allowin = 1'b0;
        enter_load(32'h104, 5'd6, 32'h0000_2002, c_ld_hu);
        push(32'h104, 32'h0000_BEEF, 5'd6);
        step();
        idle();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hBEEF_0000;
        step();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'hDEAD_DEAD;
        #1;
        check("t2_held_valid", {63'b0, out_valid}, 64'd1);
        check("t2_not_pending", {63'b0, fwd_pending}, 64'd0);
        check("t2_allowin_low", {63'b0, mem_allowin}, 64'd0);
        step();
        step();
        wb_allowin = 1'b1;
        step();
        #1;
        check("t2_left", {63'b0, out_valid}, 64'd0);
        check("t2_one_pulse", 64'(nxfer - x0), 64'd1);

        // 3: flush a pending load; the old response arrives with a new load
        enter_load(32'h200, 5'd7, 32'h0000_3000, c_ld_w);
        step();
        idle();
        flush = 1'b1;
        #1;
        check("t3_flush_no_out", {63'b0, out_valid}, 64'd0);
        step();
        idle();
        enter_load(32'h300, 5'd8, 32'h0000_3004, c_ld_w);
        push(32'h300, 32'hCAFE_F00D, 5'd8);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h0000_1234;
        step();
        idle();
        #1;
        check("t3_new_waits", {63'b0, fwd_pending}, 64'd1);
        step();
        check("t3_still_waits", {63'b0, out_valid}, 64'd0);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hCAFE_F00D;
        #1;
        check("t3_own_data", {63'b0, out_valid}, 64'd1);
        step();
        idle();

        // 4: flush a pending load and an incoming request: two stale responses
        enter_load(32'h400, 5'd9, 32'h0000_4000, c_ld_w);
        step();
        idle();
        enter_load(32'h500, 5'd10, 32'h0000_5000, c_ld_w);
        flush = 1'b1;
        step();
        idle();
        enter_load(32'h600, 5'd11, 32'h0000_6000, c_ld_w);
        push(32'h600, 32'h6666_0001, 5'd11);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h4444_0000;
        step();
        idle();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h5555_0000;
        #1;
        check("t4_stale2_dropped", {63'b0, out_valid}, 64'd0);
        check("t4_stale2_pending", {63'b0, fwd_pending}, 64'd1);
        step();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h6666_0001;
        #1;
        check("t4_own_data", {63'b0, out_valid}, 64'd1);
        step();
        idle();

        // 5: multiplier final add and plain ALU pass-through, back to back
        in_add1 = 68'h1_0000_0000;
        in_add2 = 68'h0_FFFF_FFFF;
        in_cin  = 1'b1;
        enter_alu(32'h700, 5'd12, 32'h0000_0077, 3'b100);
`ifdef MEM_MUL_FINAL_ADD_EN
        push(32'h700, 32'h0000_0000, 5'd12);
`else
        push(32'h700, 32'h0000_0077, 5'd12);
`endif
        step();
        check("t5_mul_fwd_mem", {63'b0, fwd_from_mem}, 64'd0);
        enter_alu(32'h704, 5'd13, 32'h0000_0088, 3'b010);
`ifdef MEM_MUL_FINAL_ADD_EN
        push(32'h704, 32'h0000_0002, 5'd13);
`else
        push(32'h704, 32'h0000_0088, 5'd13);
`endif
        step();
        enter_alu(32'h708, 5'd14, 32'h1234_5678, 3'b000);
        push(32'h708, 32'h1234_5678, 5'd14);
        step();
        idle();
        step();

        // 6: store waits for data_ok, no forwarding
        enter_load(32'h800, 5'd15, 32'h0000_8000, 5'b00000);
        in_rfrom_mem = 1'b0;
        in_gr_we     = 1'b0;
        push(32'h800, 32'h0000_8000, 5'd15);
        step();
        idle();
        #1;
        check("t6_store_waits", {63'b0, out_valid}, 64'd0);
        check("t6_store_nopend", {63'b0, fwd_pending}, 64'd0);
        check("t6_store_nofwd", {59'b0, fwd_dest}, 64'd0);
        step();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hFFFF_FFFF;
        step();
        idle();

        // 7: async reset while a load waits and a discard is owed
        enter_load(32'h900, 5'd16, 32'h0000_9000, c_ld_w);
        step();
        idle();
        flush = 1'b1;
        step();
        idle();
        enter_load(32'h904, 5'd17, 32'h0000_9004, c_ld_w);
        step();
        idle();
        #1;
        check("t7_waiting", {63'b0, fwd_pending}, 64'd1);
        #1;
        resetn = 1'b0;
        #1;
        check("t7_rst_out_valid", {63'b0, out_valid}, 64'd0);
        check("t7_rst_fwd_dest", {59'b0, fwd_dest}, 64'd0);
        check("t7_rst_pending", {63'b0, fwd_pending}, 64'd0);
        check("t7_rst_allowin", {63'b0, mem_allowin}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        step();
        // A cleared discard counter lets the first response match directly.
        enter_load(32'h908, 5'd18, 32'h0000_9001, c_ld_bu);
        push(32'h908, 32'h0000_00AB, 5'd18);
        step();
        idle();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h0000_AB00;
        #1;
        check("t7_after_rst_match", {63'b0, out_valid}, 64'd1);
        step();
        idle();
        step();
        step();

        check("sb_empty", 64'(sb.size()), 64'd0);
        check("xfer_count", 64'(nxfer), 64'(npush));
        $display("test done: total=%0d bad=%0d", nchk, nbad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_stage_vlat.md
Name: mem_stage_vlat

Overview:
- Parametrised memory-access pipeline stage for variable-latency data SRAM (request/response split).
- Sits between EXE and WB. The request is issued in EXE; this stage waits for the matching response (data_ok).
- Aligns and extends load data, completes the multiplier final add, and produces forwarding info for ID.
- Buffers an early response when WB stalls, and discards stale responses after a flush.

Parameters:
PC_W, 32, pc width
DATA_W, 32, data/result width (must be 32 for byte/half alignment logic)
DEST_W, 5, register index width
MUL_W, 68, partial-sum width for multiplier final add
MAX_OUTST, 2, maximum responses that may be in flight to discard; discard counter width = clog2(MAX_OUTST+1)

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
flush  in  1  kill current MEM instruction (exception/ertn)
in_valid  in  1  EXE has an instruction for MEM
in_pc  in  PC_W  instruction pc
in_gr_we  in  1  register write enable
in_dest  in  DEST_W  destination register
in_exe_result  in  DATA_W  ALU result / data address
in_mem_req  in  1  a data SRAM request was accepted (addr_ok) in EXE for this instruction
in_load_op  in  5  one-hot {LD_W,LD_HU,LD_H,LD_BU,LD_B}
in_rfrom_mem  in  1  result comes from memory
in_mul_op  in  3  one-hot {MUL_L,MULH,MULHU}; 0 = not a multiply
in_add1, in_add2  in  MUL_W  multiplier partial sums
in_cin  in  1  multiplier carry-in
data_sram_data_ok  in  1  response valid
data_sram_rdata  in  DATA_W  response data
wb_allowin  in  1  WB can accept
mem_allowin  out  1  MEM can accept
out_valid  out  1  MEM-to-WB valid
out_pc  out  PC_W  pc to WB
out_gr_we  out  1  write enable to WB
out_dest  out  DEST_W  dest to WB
out_result  out  DATA_W  final result to WB
fwd_dest  out  DEST_W  dest for forwarding; 0 when not valid or gr_we=0
fwd_from_mem  out  1  forwarded value is a load
fwd_pending  out  1  load result not yet available (ID must stall)

Behaviour:
- Reset (async, resetn=0): valid=0, input latch=0, got_data=0, data buffer=0, discard_cnt=0. Hence out_valid=0, fwd_dest=0, fwd_pending=0, mem_allowin=1.
- Latch inputs when in_valid && mem_allowin && !flush. Valid update:
  - flush → valid=0.
  - else if mem_allowin → valid=in_valid.
- A response is stale when data_ok=1 and discard_cnt>0. A stale response decrements discard_cnt, is dropped, and is never matched to the current instruction (older requests first).
- A non-stale data_ok while valid && mem_req && !got_data matches the current instruction.
- ready_go = !mem_req || got_data || matching data_ok.
- out_valid = valid && ready_go && !flush.
- mem_allowin = !valid || (ready_go && wb_allowin).
- Matching data_ok with wb_allowin=0: store rdata in buffer, set got_data=1. Clear got_data when the instruction leaves or is flushed.
- Load data source: got_data ? buffer : data_sram_rdata. Shift right by {exe_result[1:0],3'b0}. Then:
  - LD_B/LD_BU: sign/zero-extend byte.
  - LD_H/LD_HU: sign/zero-extend half.
  - LD_W: full word.
- Result: rfrom_mem ? load data : (MUL_L ? sum[31:0] : MULH|MULHU ? sum[63:32] : exe_result), where sum = add1+add2+cin, MUL_W wide.
- fwd_pending = valid && rfrom_mem && !ready_go.
- Flush while valid && mem_req && !got_data && no matching data_ok this cycle: discard_cnt += 1.
- Flush while in_valid && in_mem_req: discard_cnt += 1 (the incoming instruction is not latched). Increments sum; concurrent stale decrement nets out.
- discard_cnt saturates at MAX_OUTST. Overflow is an upstream protocol error, and the assertion must fire in simulation.
- Stores (mem_req, !rfrom_mem) also wait for data_ok.

Optional Feature:
MEM_MUL_FINAL_ADD_EN:
- Defined: behaviour as above.
- Undefined: in_add1/in_add2/in_cin/in_mul_op are ignored, no adder is synthesised, and the non-load result = exe_result.

Test Plan:
- Load LD_B, exe_result[1:0]=3, data_ok 2 cycles after entry with rdata=0x80FF_FF12, wb_allowin=1 → fwd_pending=1 for 2 cycles, then out_valid=1 with out_result=0xFFFF_FF80.
- LD_HU, addr[1:0]=2, data_ok with rdata=0xBEEF_0000 while wb_allowin=0 → got_data set; wb_allowin=1 after 3 cycles → out_result=0x0000_BEEF, exactly one out_valid pulse.
- Flush with a pending load, then data_ok=1 next cycle with rdata=0x1234 and a new load entering → old response dropped (discard_cnt 1→0); new load waits for its own data_ok.
- Flush with a pending load plus an incoming in_mem_req → discard_cnt=2; two data_ok pulses both dropped, out_valid stays 0.
- MUL_L, add1=0x1_0000_0000, add2=0xFFFF_FFFF, cin=1 → out_result=0x0000_0000; MULH on the same inputs → 0x0000_0002 (macro defined).
- Assert resetn=0 mid-wait (async, between clock edges) → out_valid, fwd_dest and discard_cnt are 0 immediately, and mem_allowin=1.
